// File: rtl/int8_mac_instr_pkg.sv
// Shared definitions for the INT8 MAC instruction path.
package int8_mac_instr_pkg;

  // Cycles from the issue handshake to mac_valid_i from the MAC unit.
  localparam int MAC_UNIT_LATENCY = 1;

  // Width of an architectural register index.
  localparam int RD_W = 5;

endpackage : int8_mac_instr_pkg

// File: rtl/int8_mac_result_fifo.sv
// Generic DEPTH-entry FIFO with wrap-bit pointers, full/empty flags and occupancy.
// A push while full succeeds only if a pop happens in the same cycle.
module int8_mac_result_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  entry_t                     data_i,
  input  logic                       pop_i,
  output entry_t                     data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  entry_t      mem_q [DEPTH];
  logic        push_en;
  logic        pop_en;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // When full, the write slot equals the head slot; the head is read before the edge, so push+pop is safe.
  assign push_en = push_i && (!full_o || pop_i);
  assign pop_en  = pop_i && !empty_o;

  // Pointer advance; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Entry storage; contents are meaningless while the pointers call the slot empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule : int8_mac_result_fifo

// File: rtl/int8_mac_writeback.sv
// Receiving end of the INT8 MAC result interface. The MAC unit cannot stall, so its
// results are buffered and replayed to the core under valid/ready. An issue credit
// keeps the buffer from overflowing; saturation and protocol-error status kept here too.
module int8_mac_writeback
  import int8_mac_instr_pkg::*;
#(
  parameter int  XLEN     = 32,
  parameter int  DEPTH    = 4,
  parameter int  CNT_W    = 16,
  parameter type hartid_t = logic,
  parameter type id_t     = logic
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             issue_fire_i,
  output logic             issue_ready_o,
  input  logic             mac_valid_i,
  input  logic             mac_we_i,
  input  logic [XLEN-1:0]  mac_result_i,
  input  logic [RD_W-1:0]  mac_rd_addr_i,
  input  hartid_t          mac_hartid_i,
  input  id_t              mac_id_i,
  input  logic             mac_overflow_i,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic [XLEN-1:0]  result_data_o,
  output logic [RD_W-1:0]  result_rd_o,
  output logic             result_we_o,
  output hartid_t          result_hartid_o,
  output id_t              result_id_o,
  input  logic             sat_clear_i,
  output logic             sat_sticky_o,
  output logic [CNT_W-1:0] sat_count_o,
  output logic             overflow_err_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [RD_W-1:0] rd;
    logic            we;
    hartid_t         hartid;
    id_t             id;
  } entry_t;

  entry_t          push_entry;
  entry_t          head_entry;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            pop;
  logic            inflight_q;
  logic [CW:0]     credit_sum;
  logic            sat_event;
  logic            sat_sticky_q;
  logic [CNT_W-1:0] sat_count_q;
  logic            overflow_err_q;

  assign push_entry = '{result: mac_result_i, rd: mac_rd_addr_i, we: mac_we_i,
                        hartid: mac_hartid_i, id: mac_id_i};

  int8_mac_result_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (mac_valid_i),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign result_valid_o  = !fifo_empty;
  assign pop             = result_valid_o && result_ready_i;
  assign result_data_o   = head_entry.result;
  assign result_rd_o     = head_entry.rd;
  assign result_we_o     = head_entry.we;
  assign result_hartid_o = head_entry.hartid;
  assign result_id_o     = head_entry.id;

  // Credit counts buffered entries plus the one result the unit may still deliver.
  // A same-cycle pop is deliberately not credited to keep result_ready_i off this path.
  assign credit_sum    = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign issue_ready_o = credit_sum < (CW+1)'(DEPTH);

  // One-cycle unit latency: a fire is in flight for exactly one cycle. An illegal
  // opcode produces no result, so its credit simply lapses the next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) inflight_q <= 1'b0;
    else         inflight_q <= issue_fire_i;
  end

  // A push into a full FIFO with no pop is lost; flag it until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                   overflow_err_q <= 1'b0;
    else if (mac_valid_i && fifo_full && !pop)     overflow_err_q <= 1'b1;
  end

  // Saturation status; dropped pushes still count, and a same-cycle event wins over clear.
  assign sat_event = mac_valid_i && mac_overflow_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sat_sticky_q <= 1'b0;
      sat_count_q  <= '0;
    end else if (sat_clear_i) begin
      sat_sticky_q <= sat_event;
      sat_count_q  <= {{(CNT_W-1){1'b0}}, sat_event};
    end else if (sat_event) begin
      sat_sticky_q <= 1'b1;
      if (!(&sat_count_q)) sat_count_q <= sat_count_q + 1'b1;
    end
  end

  assign sat_sticky_o   = sat_sticky_q;
  assign sat_count_o    = sat_count_q;
  assign overflow_err_o = overflow_err_q;

endmodule : int8_mac_writeback
